// File: rtl/max_seq_pkg.sv
// Shared register map, control/status bit positions and scan FSM encoding
// for the max_seq_ctrl peripheral.
package max_seq_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_PUSH   = 3'd2;
  localparam logic [2:0] ADDR_MAX    = 3'd3;
  localparam logic [2:0] ADDR_IDX    = 3'd4;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_ERR_EMPTY = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [31:0] pack_status(
    input logic       busy,
    input logic       done,
    input logic       err_empty,
    input logic       overflow,
    input logic [8:0] count
  );
    logic [31:0] s;
    s                                  = 32'd0;
    s[STAT_BUSY]                       = busy;
    s[STAT_DONE]                       = done;
    s[STAT_ERR_EMPTY]                  = err_empty;
    s[STAT_OVERFLOW]                   = overflow;
    s[STAT_COUNT_LSB +: STAT_COUNT_W]  = count;
    return s;
  endfunction

endpackage

// File: rtl/max_seq_cmp.sv
// Candidate-vs-running-max select for the scan datapath; strict greater-than,
// so ties keep the earlier index. Signed compare when MAX_SEQ_CTRL_SIGNED_EN is defined.
module max_seq_cmp #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic [DATA_W-1:0] cand,
  input  logic [IDX_W-1:0]  cand_idx,
  input  logic [DATA_W-1:0] cur_max,
  input  logic [IDX_W-1:0]  cur_idx,
  output logic [DATA_W-1:0] sel_max,
  output logic [IDX_W-1:0]  sel_idx
);

  logic take_s;

`ifdef MAX_SEQ_CTRL_SIGNED_EN
  assign take_s = ($signed(cand) > $signed(cur_max));
`else
  assign take_s = (cand > cur_max);
`endif

  // Select the larger operand and its index
  always_comb begin
    if (take_s) begin
      sel_max = cand;
      sel_idx = cand_idx;
    end else begin
      sel_max = cur_max;
      sel_idx = cur_idx;
    end
  end

endmodule

// File: rtl/max_seq_ctrl.sv
// Bus-mapped max-search sequencer: buffers operands, scans one per clock and
// reports max and first index. MAX_SEQ_CTRL_SIGNED_EN selects signed operands.
module max_seq_ctrl
  import max_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iChipselect_n,
  input  logic        iWrite_n,
  input  logic        iRead_n,
  input  logic [2:0]  iAddress,
  input  logic [31:0] iData,
  output logic [31:0] oData
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [DATA_W-1:0] DAT_ZERO = {DATA_W{1'b0}};

  logic              wr_s, rd_s, start_s, clear_s, push_s, push_ok_s;
  logic              unused_s;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d, ptr_q, ptr_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              err_empty_q, err_empty_d, overflow_q, overflow_d;
  logic [DATA_W-1:0] run_max_q, run_max_d, max_r_q, max_r_d, sel_max_s;
  logic [IDX_W-1:0]  run_idx_q, run_idx_d, idx_r_q, idx_r_d, sel_idx_s;
  logic [31:0]       rdata_q, rdata_d, max_ext_s;
  logic [DATA_W-1:0] buf_q [DEPTH];

  assign wr_s      = ~iChipselect_n & ~iWrite_n;
  assign rd_s      = ~iChipselect_n & ~iRead_n;
  assign clear_s   = wr_s & (iAddress == ADDR_CTRL) & iData[CTRL_CLEAR];
  assign start_s   = wr_s & (iAddress == ADDR_CTRL) & iData[CTRL_START] & ~iData[CTRL_CLEAR];
  assign push_s    = wr_s & (iAddress == ADDR_PUSH);
  assign push_ok_s = push_s & ~busy_q & (count_q != CNT_FULL);
  assign unused_s  = ^iData[31:DATA_W];

`ifdef MAX_SEQ_CTRL_SIGNED_EN
  assign max_ext_s = 32'($signed(max_r_q));
`else
  assign max_ext_s = 32'(max_r_q);
`endif

  max_seq_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .cand     (buf_q[ptr_q[IDX_W-1:0]]),
    .cand_idx (ptr_q[IDX_W-1:0]),
    .cur_max  (run_max_q),
    .cur_idx  (run_idx_q),
    .sel_max  (sel_max_s),
    .sel_idx  (sel_idx_s)
  );

  // Next-state logic for the scan FSM, flags and operand count
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_empty_d = err_empty_q;
    overflow_d  = overflow_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    max_r_d     = max_r_q;
    idx_r_d     = idx_r_q;
    if (clear_s) begin
      state_d     = IDLE;
      count_d     = CNT_ZERO;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      err_empty_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_s) begin
            if (count_q != CNT_ZERO) begin
              state_d     = SCAN;
              busy_d      = 1'b1;
              done_d      = 1'b0;
              err_empty_d = 1'b0;
              run_max_d   = buf_q[IDX_ZERO];
              run_idx_d   = IDX_ZERO;
              ptr_d       = CNT_ONE;
            end else begin
              state_d     = DONE;
              done_d      = 1'b1;
              err_empty_d = 1'b1;
              max_r_d     = DAT_ZERO;
              idx_r_d     = IDX_ZERO;
            end
          end else begin
            state_d = IDLE;
          end
        end
        SCAN: begin
          // ptr reaching count means every element has been folded in
          if (ptr_q == count_q) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            max_r_d = run_max_q;
            idx_r_d = run_idx_q;
          end else begin
            run_max_d = sel_max_s;
            run_idx_d = sel_idx_s;
            ptr_d     = ptr_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
      if (push_s) begin
        if (push_ok_s) begin
          count_d = count_q + CNT_ONE;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // Read-data mux; oData holds when no read is strobed
  always_comb begin
    rdata_d = rdata_q;
    if (rd_s) begin
      case (iAddress)
        ADDR_STATUS: rdata_d = pack_status(busy_q, done_q, err_empty_q, overflow_q,
                                           STAT_COUNT_W'(count_q));
        ADDR_MAX:    rdata_d = max_ext_s;
        ADDR_IDX:    rdata_d = 32'(idx_r_q);
        default:     rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control and result registers
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q     <= IDLE;
      count_q     <= CNT_ZERO;
      ptr_q       <= CNT_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_empty_q <= 1'b0;
      overflow_q  <= 1'b0;
      run_max_q   <= DAT_ZERO;
      run_idx_q   <= IDX_ZERO;
      max_r_q     <= DAT_ZERO;
      idx_r_q     <= IDX_ZERO;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_empty_q <= err_empty_d;
      overflow_q  <= overflow_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      max_r_q     <= max_r_d;
      idx_r_q     <= idx_r_d;
      rdata_q     <= rdata_d;
    end
  end

  // Operand buffer; contents survive reset and CLEAR
  always_ff @(posedge iClk) begin
    if (push_ok_s) begin
      buf_q[count_q[IDX_W-1:0]] <= iData[DATA_W-1:0];
    end
  end

  assign oData = rdata_q;

endmodule

// File: doc/max_seq_ctrl.md
Name: max_seq_ctrl

Overview:
- Memory-mapped controller that buffers up to DEPTH operands written by the CPU over the bus.
- On command, it scans the buffer one element per clock and reports the maximum value and the index of its first occurrence.
- It sequences a max search over an arbitrary-length list, where the existing find-max peripheral compares only a fixed packed word.
- Sits on the same slave bus as the other peripherals (chip-select / read / write strobes, registered read data).

Parameters:
- DATA_W, 8, operand width in bits (1..31).
- DEPTH, 16, buffer entries (power of two, 2..256); IDX_W = $clog2(DEPTH) is derived, not overridable.

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iReset_n  in  1  reset; synchronous, active-low.
- iChipselect_n  in  1  slave select, active-low.
- iWrite_n  in  1  write strobe, active-low.
- iRead_n  in  1  read strobe, active-low.
- iAddress  in  3  register select.
- iData  in  32  write data.
- oData  out  32  read data, registered.

Behaviour:
- Reset (iReset_n low at a clock edge): oData=0, state=IDLE, count=0, busy=0, done=0, err_empty=0, overflow=0, max_r=0, idx_r=0. Buffer contents are not reset.
- Register map. Reads have 1-cycle latency; oData is updated on the edge where cs & read are asserted and holds otherwise. Unmapped addresses read 0 and ignore writes.
  - addr0 CTRL (write-only, reads 0): bit0=START, bit1=CLEAR.
  - addr1 STATUS (read): bit0 busy, bit1 done, bit2 err_empty, bit3 overflow, bits[16:8] count; all others 0.
  - addr2 PUSH (write): buf[count] <= iData[DATA_W-1:0]; count++.
  - addr3 MAX (read): zero-extended max_r.
  - addr4 IDX (read): zero-extended idx_r.
- FSM states: IDLE, SCAN, DONE.
- IDLE + START, count>0:
  - go to SCAN, busy=1, done=0.
  - running max = buf[0], running idx = 0, ptr = 1.
- IDLE + START, count==0: go to DONE next cycle; err_empty=1, max_r=0, idx_r=0.
- SCAN, per cycle:
  - if buf[ptr] > running max (strict, unsigned), update the running max and running idx. Ties keep the lower index.
  - ptr++; when ptr==count, go to DONE.
- Entering DONE: max_r and idx_r load the running values; busy=0, done=1.
  - START latency = count cycles from the START write edge to done=1 (count==1 → 1 cycle).
  - DONE returns to IDLE the following cycle; done stays sticky until the next START or CLEAR.
- max_r/idx_r change only on entering DONE; reads during SCAN return the previous result.
- PUSH rules:
  - PUSH while busy: ignored, overflow=1.
  - PUSH when count==DEPTH: ignored, overflow=1.
- CLEAR: in any state, next cycle count=0, state=IDLE, busy=0, done=0, err_empty=0, overflow=0. max_r/idx_r are retained. CLEAR during SCAN aborts without updating results.
- START and CLEAR set in the same write: CLEAR wins.
- START while busy: ignored, no flag.
- err_empty is cleared by the next START with count>0, or by CLEAR.
- Buffer is preserved after a scan, so repeated START rescans the same data.
- A read and a write in the same cycle are both honoured. A STATUS read in the same cycle as START returns pre-START values.

Optional Feature:
- Macro MAX_SEQ_CTRL_SIGNED_EN.
  - Defined: operands are compared as two's-complement DATA_W-bit values; MAX read data is sign-extended to 32 bits.
  - Undefined: unsigned compare, zero-extended read data.

Decomposition:
- Shared package max_seq_pkg:
  - register address constants ADDR_CTRL=0, ADDR_STATUS=1, ADDR_PUSH=2, ADDR_MAX=3, ADDR_IDX=4;
  - CTRL bit positions; STATUS bit positions;
  - FSM state enum (IDLE/SCAN/DONE, 2-bit encoding).
- One natural sub-module: max_seq_cmp, a combinational compare/select of candidate vs running max (honours the SIGNED macro), instantiated once in the scan datapath.
- Buffer, FSM and bus decode stay in the top.

Test Plan:
- Reset, then read STATUS, MAX, IDX → all 0 one cycle after each read.
- PUSH 3, 9, 4, 9, 1; START; poll STATUS → busy for 5 cycles, then done=1; MAX=9, IDX=1 (first of the tie).
- START with count 0 → done=1, err_empty=1, MAX=0. Then PUSH 7, START → err_empty=0, MAX=7, IDX=0, latency 1 cycle.
- Fill DEPTH=16 entries, 17th PUSH → overflow=1, count=16. A PUSH during SCAN → ignored, overflow=1, result unaffected.
- START with 16 entries, CLEAR at cycle 5 → busy=0, done=0, count=0; MAX/IDX keep the prior scan's values.
- Signed build: PUSH 0x80, 0x7F, 0xFF; START → MAX=0x0000007F, IDX=1. Unsigned build, same data → MAX=0xFF, IDX=2.
